fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Pipelined successor to the single-request fetch unit. It keeps up to MAX_OUTSTANDING instruction-cache requests in flight and buffers returned instructions with their PCs in a FIFO_DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Sits between the instruction cache and decode; a branch redirect from the ALU flushes the queue and discards stale in-flight responses.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, instruction address / PC width
START_ADDR, 32'hFFFFFFFF, fetch PC loaded on reset
FIFO_DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum cache requests in flight (1..FIFO_DEPTH)
PC_STEP, 1, PC increment per sequential fetch (word-addressed)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_req  out  1  cache request valid
inst_addr  out  ADDR_WIDTH  request address (current fetch PC)
inst_ready  in  1  cache accepts request this cycle
inst_valid  in  1  in-order response valid, one word per cycle
inst_data  in  DATA_WIDTH  response word
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode consumes head
inst  out  DATA_WIDTH  head instruction
pc  out  ADDR_WIDTH  head instruction PC
redirect_valid  in  1  branch taken / redirect
redirect_pc  in  ADDR_WIDTH  redirect target
busy  out  1  outstanding != 0 or drop_cnt != 0

Behaviour:
- Reset: fetch_pc=START_ADDR, resp_pc=START_ADDR, outstanding=0, drop_cnt=0, queue empty. Outputs: inst_req=0, out_valid=0, inst=0, pc=0, busy=0. Reset mid-operation abandons all in-flight requests; responses arriving after reset is released are not guarded against, and the cache must be reset with the fetch unit.
- Issue: inst_req=1 when not in reset, outstanding < MAX_OUTSTANDING, and (outstanding + drop_cnt + count) < FIFO_DEPTH. Issue reserves a queue slot, so there is never response backpressure.
- Accept: inst_req && inst_ready. Then outstanding increments and fetch_pc += PC_STEP, wrapping modulo 2^ADDR_WIDTH.
- inst_req and inst_addr are combinational from registered state. inst_addr must stay stable while inst_req=1 and not accepted.
- Response handling with drop_cnt > 0: the word is discarded and drop_cnt decrements.
- Response handling with drop_cnt = 0: push {resp_pc, inst_data}, then resp_pc += PC_STEP and outstanding decrements.
- Response latency is at least 1 cycle after accept. A response and an accept in the same cycle give a net outstanding change of 0.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle keep count unchanged. A push into an empty queue is visible on out_valid the next cycle; there is no bypass.
- Redirect, applied at the clock edge and taking priority over push and pop:
  - queue cleared; fetch_pc and resp_pc set to redirect_pc;
  - drop_cnt becomes old drop_cnt + outstanding + (accept this cycle) - (valid response this cycle);
  - outstanding becomes 0;
  - any response arriving that cycle is discarded;
  - decode's pop in that cycle is ignored; decode must not treat it as consumed;
  - out_valid=0 the cycle after.
- A new request may issue in the cycle after redirect, at redirect_pc, subject to the slot rule (drop_cnt counts against slots).
- Back-to-back redirects: each one reloads the PCs and accumulates drop_cnt.
- Widths: outstanding and drop_cnt are $clog2(FIFO_DEPTH+1) bits each; count is $clog2(FIFO_DEPTH+1) bits.
- FSM over fetch status, used for busy/debug only:
  - RUN (drop_cnt=0) -> DRAIN on a redirect with in-flight requests;
  - DRAIN -> RUN when drop_cnt reaches 0 with no new redirect.

Decomposition:
- Package fetch_pkg: fetch_entry_t {pc, inst}; localparams for the PC_STEP default, START_ADDR default, and counter width function.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH parameter, push/pop/clear ports, count and full/empty outputs. Clear has priority over push and pop.

Test Plan:
- Reset, START_ADDR=0, cache ready always, 1-cycle latency, out_ready=1 -> addresses 0,1,2,3…; out pc/inst pairs in order, one per cycle after fill.
- out_ready=0, FIFO_DEPTH=4 -> exactly 4 accepted requests; inst_req=0 afterwards; out_valid=1 with pc=0 held stable.
- Redirect to 0x100 with 2 requests outstanding (3-cycle latency) -> next 2 responses dropped; first popped pc=0x100; busy=1 until drop_cnt=0.
- Redirect in the same cycle as an accept, a response, and a pop -> popped entry not removed (queue cleared); drop_cnt = outstanding+1-1; next pc=target.
- fetch_pc=0xFFFFFFFF (reset value), PC_STEP=1 -> second request address 0x00000000 (wrap).
- Assert rst while 2 requests are outstanding and the queue is full -> next cycle inst_req=0 and out_valid=0; after release, inst_addr=START_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the pipelined prefetching fetch unit.
package fetch_pkg;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefAddrWidth = 32;
   localparam logic [DefAddrWidth-1:0] DefStartAddr = 32'hFFFF_FFFF;
   localparam int unsigned DefPcStep = 1;

   typedef struct packed {
      logic [DefAddrWidth-1:0] pc;
      logic [DefDataWidth-1:0] inst;
   } fetch_entry_t;

   typedef enum logic [0:0] {StRun, StDrain} fetch_state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Cache request/response, decode handshake and redirect signals of the fetch unit.
interface fetch_prefetch_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_ready;
   logic                  inst_valid;
   logic [DATA_WIDTH-1:0] inst_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  busy;

   modport master (
      output inst_req, inst_addr, out_valid, inst, pc, busy,
      input  inst_ready, inst_valid, inst_data, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  inst_req, inst_addr, out_valid, inst, pc, busy,
      output inst_ready, inst_valid, inst_data, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; clear wins over push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int unsigned CntW = cnt_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            push,
   input  entry_t          push_data,
   input  logic            pop,
   output entry_t          head,
   output logic [CntW-1:0] count,
   output logic            full,
   output logic            empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   entry_t            mem_q [DEPTH];
   logic [PtrW-1:0]   wr_q, rd_q;
   logic [CntW-1:0]   count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clear) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch unit with several cache requests in flight and a prefetch queue toward decode.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(DefStartAddr),
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned PC_STEP = DefPcStep
) (
   input logic              clk,
   input logic              rst,
   fetch_prefetch_if.master bus
);

   localparam int unsigned CW = cnt_width(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(PC_STEP);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] inst;
   } prefetch_entry_t;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]         out_q, out_d, drop_q, drop_d, q_count;
   logic [CW+1:0]         used;
   fetch_state_e          state_q, state_d;
   logic                  req, accept, push, pop, clear, q_full, q_empty, draining;
   prefetch_entry_t       head;

   // Every issued request already owns a queue slot, so responses are never refused.
   assign used   = (CW+2)'(out_q) + (CW+2)'(drop_q) + (CW+2)'(q_count);
   assign req    = !rst && (out_q < CW'(MAX_OUTSTANDING)) && (used < (CW+2)'(FIFO_DEPTH))
                   && !q_full;
   assign accept = req && bus.inst_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b0;
      if (bus.redirect_valid) begin
         clear      = 1'b1;
         fetch_pc_d = bus.redirect_pc;
         resp_pc_d  = bus.redirect_pc;
         out_d      = '0;
         drop_d     = drop_q + out_q + CW'(accept) - CW'(bus.inst_valid);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + Step;
         if (bus.inst_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + Step;
            end
         end
         out_d = out_q + CW'(accept) - CW'(push);
         pop   = !q_empty && bus.out_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= START_ADDR;
         resp_pc_q  <= START_ADDR;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   // Status FSM: DRAIN exactly while stale responses remain to be discarded.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StRun;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (bus.redirect_valid && drop_d != '0) state_d = StDrain;
         StDrain: if (drop_d == '0) state_d = StRun;
      endcase
   end

   always_comb begin
      draining = (state_q == StDrain);
   end

   fetch_queue #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (prefetch_entry_t)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .push_data ({resp_pc_q, bus.inst_data}),
      .pop       (pop),
      .head      (head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign bus.inst_req  = req;
   assign bus.inst_addr = fetch_pc_q;
   assign bus.out_valid = !q_empty;
   assign bus.inst      = head.inst;
   assign bus.pc        = head.pc;
   assign bus.busy      = (out_q != '0) || draining;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized scoreboard bench for fetch_prefetch with an in-bench cache and PC-stream model.
module tb_fetch_prefetch;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO = 2;
   localparam logic [31:0] START = 32'hFFFF_FFFF;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        inst_ready_r = 1'b0;
   logic        inst_valid_r = 1'b0;
   logic [31:0] inst_data_r = '0;
   logic        out_ready_r = 1'b0;
   logic        redir_r = 1'b0;
   logic [31:0] redir_pc_r = '0;

   fetch_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   assign bus.inst_ready     = inst_ready_r;
   assign bus.inst_valid     = inst_valid_r;
   assign bus.inst_data      = inst_data_r;
   assign bus.out_ready      = out_ready_r;
   assign bus.redirect_valid = redir_r;
   assign bus.redirect_pc    = redir_pc_r;

   fetch_prefetch #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .START_ADDR      (START),
      .FIFO_DEPTH      (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .PC_STEP         (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int checks = 0;
   int failures = 0;

   // Controls written only by the main sequence.
   logic        rst_req = 1'b1;
   int          p_iready = 100, p_oready = 100, p_redir = 0;
   int          lat_min = 1, lat_max = 1;
   logic        force_redir = 1'b0;
   logic [31:0] force_tgt = '0;

   // Models written only by the driver.
   exp_t        sb[$];
   pend_t       pending[$];
   logic [31:0] acc_addr[$];
   logic [31:0] model_pc = START;
   logic [31:0] req_pc_snap = START;
   int          inflight_snap = 0;
   int          cyc = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(3))
         0:       return 32'h0000_0100;
         1:       return 32'h0000_0000;
         2:       return 32'hFFFF_FFFE;
         default: return $urandom;
      endcase
   endfunction

   // Driver: decode, redirect and cache stimulus; cache responds in order after its latency.
   always @(negedge clk) begin
      cyc++;
      inflight_snap = pending.size();
      req_pc_snap   = model_pc;
      rst           = rst_req;
      inst_valid_r  = 1'b0;
      inst_ready_r  = ($urandom_range(99) < p_iready);
      out_ready_r   = ($urandom_range(99) < p_oready);
      redir_r       = !rst_req && (force_redir || ($urandom_range(99) < p_redir));
      redir_pc_r    = force_redir ? force_tgt : pick_target();
      if (rst_req) begin
         pending.delete();
         sb.delete();
         acc_addr.delete();
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
         inst_valid_r = 1'b1;
         inst_data_r  = word_at(pending[0].addr);
         void'(pending.pop_front());
      end
      if (redir_r) sb.delete();
      #1;
      if (bus.inst_req && inst_ready_r) begin
         pending.push_back('{bus.inst_addr, cyc + $urandom_range(lat_max, lat_min)});
         acc_addr.push_back(bus.inst_addr);
         if (!redir_r) sb.push_back('{model_pc, word_at(model_pc)});
         model_pc = model_pc + 32'd1;
      end
      if (redir_r) model_pc = redir_pc_r;
      if (rst_req) model_pc = START;
   end

   // Monitor: compares the DUT against the scoreboard and the request/in-flight models.
   logic redir_prev = 1'b0;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         redir_prev = 1'b0;
      end else begin
         if (bus.inst_req) check("inst_addr", bus.inst_addr, req_pc_snap);
         check("busy", 32'(bus.busy), 32'(inflight_snap != 0));
         if (redir_prev) check("out_valid_after_redirect", 32'(bus.out_valid), 32'd0);
         if (bus.out_valid && !redir_r) begin
            if (sb.size() == 0) begin
               check("out_valid_spurious", 32'(bus.out_valid), 32'd0);
            end else begin
               check("head_pc", bus.pc, sb[0].pc);
               check("head_inst", bus.inst, sb[0].inst);
               if (out_ready_r) void'(sb.pop_front());
            end
         end
         redir_prev = redir_r;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      rst_req = 1'b1;
      repeat (3) @(posedge clk);
      rst_req = 1'b0;
   endtask

   task automatic sample();
      @(negedge clk);
      #3;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      sample();
      check("rst_inst_req", 32'(bus.inst_req), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_pc", bus.pc, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      rst_req = 1'b0;
      sample();
      check("first_req", 32'(bus.inst_req), 32'd1);
      check("first_addr", bus.inst_addr, START);

      // Streaming with 1-cycle latency; PC wraps after the reset address.
      repeat (20) @(posedge clk);
      check("acc_count_ge2", 32'(acc_addr.size() >= 2), 32'd1);
      if (acc_addr.size() >= 2) begin
         check("wrap_addr0", acc_addr[0], START);
         check("wrap_addr1", acc_addr[1], 32'h0000_0000);
      end

      // Decode stalled: exactly DEPTH accepted, head held.
      p_oready = 0;
      do_reset();
      repeat (15) @(posedge clk);
      sample();
      check("bp_accepts", acc_addr.size(), DEPTH);
      check("bp_inst_req", 32'(bus.inst_req), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_pc", bus.pc, START);
      repeat (3) sample();
      check("bp_pc_stable", bus.pc, START);
      check("bp_inst_stable", bus.inst, word_at(START));

      // Reset with requests outstanding and entries queued.
      lat_min = 4;
      lat_max = 4;
      do_reset();
      repeat (7) @(posedge clk);
      rst_req = 1'b1;
      repeat (2) sample();
      check("midrst_inst_req", 32'(bus.inst_req), 32'd0);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      rst_req = 1'b0;
      sample();
      check("midrst_addr", bus.inst_addr, START);

      // Redirect to 0x100 with two requests in flight at 3-cycle latency.
      p_oready = 100;
      lat_min = 3;
      lat_max = 3;
      do_reset();
      repeat (2) @(posedge clk);
      force_tgt   = 32'h0000_0100;
      force_redir = 1'b1;
      @(posedge clk);
      force_redir = 1'b0;
      sample();
      check("redir_busy", 32'(bus.busy), 32'd1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 30 && !seen; i++) begin
            sample();
            if (bus.out_valid) seen = 1'b1;
         end
         check("redir_out_seen", 32'(seen), 32'd1);
         check("redir_first_pc", bus.pc, 32'h0000_0100);
      end

      // Random traffic with redirects colliding with accepts, responses and pops.
      p_iready = 70;
      p_oready = 60;
      p_redir  = 6;
      lat_min  = 1;
      lat_max  = 4;
      repeat (3000) @(posedge clk);

      // Drain: everything accepted must reach decode and the unit must go idle.
      p_redir  = 0;
      p_iready = 0;
      p_oready = 100;
      begin
         int n = 0;
         while (n < 60 && (sb.size() != 0 || bus.busy)) begin
            sample();
            n++;
         end
      end
      sample();
      check("drain_sb_empty", sb.size(), 32'd0);
      check("drain_busy", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
